// File: rtl/decoder_fixed_point_mac_seq.sv
// Time-multiplexed fixed-point decoder layer:
//   out[j] = sat(round(sum_i w[i][j]*z[i]) + b[j]) on a single shared MAC.
// Handshake: a transfer on either side happens on a rising edge where
// valid && ready are both high; valid holds its data until that edge.
// Optional build macro DECODER_RELU_EN clamps negative results to zero.
module decoder_fixed_point_mac_seq #(
  parameter int N_input   = 2,
  parameter int M_output  = 9,
  parameter int BITSIZE   = 16,
  parameter int FRAC_BITS = 11
) (
  input  logic                           clk,
  input  logic                           reset,
  input  logic                           in_valid,
  output logic                           in_ready,
  input  logic [N_input*BITSIZE-1:0]     z,
  input  logic [N_input*M_output*BITSIZE-1:0] w,
  input  logic [M_output*BITSIZE-1:0]    b,
  output logic [M_output*BITSIZE-1:0]    out,
  output logic                           out_valid,
  input  logic                           out_ready,
  output logic                           busy
);

  localparam int IW    = (N_input > 1) ? $clog2(N_input) : 1;
  localparam int JW    = (M_output > 1) ? $clog2(M_output) : 1;
  localparam int ACC_W = 2*BITSIZE + $clog2(N_input) + 1;
  localparam int S_W   = ACC_W + 1;
  localparam logic [IW-1:0]  I_LAST = IW'(N_input - 1);
  localparam logic [JW-1:0]  J_LAST = JW'(M_output - 1);
  localparam logic [S_W-1:0] HALF   =
    {{(S_W-FRAC_BITS){1'b0}}, 1'b1, {(FRAC_BITS-1){1'b0}}};

  typedef enum logic [1:0] {IDLE, MAC, FIN, DONE} state_t;

  state_t                     state;
  logic [IW-1:0]              i_q;
  logic [JW-1:0]              j_q;
  logic signed [ACC_W-1:0]    acc;
  logic signed [BITSIZE-1:0]  z_q   [N_input];
  logic signed [BITSIZE-1:0]  w_q   [N_input][M_output];
  logic signed [BITSIZE-1:0]  b_q   [M_output];
  logic signed [BITSIZE-1:0]  res_q [M_output];

  logic                       accept;
  logic signed [2*BITSIZE-1:0] prod;
  logic [ACC_W-1:0]           prod_ext;
  logic [S_W-1:0]             b_ext;
  logic [S_W-1:0]             s_full;
  logic signed [S_W-1:0]      r_full;
  logic [S_W-BITSIZE:0]       r_hi;
  logic signed [BITSIZE-1:0]  sat_val;
  logic signed [BITSIZE-1:0]  fin_val;

  assign in_ready = (state == IDLE) && !out_valid;
  assign busy     = (state == MAC) || (state == FIN);
  assign accept   = in_valid && in_ready && !reset;

  // Shared multiplier: full-width signed product, sign-extended to the accumulator.
  assign prod     = z_q[i_q] * w_q[i_q][j_q];
  assign prod_ext = {{(ACC_W-2*BITSIZE){prod[2*BITSIZE-1]}}, prod};

  // Bias alignment, round-half-up, shift back to the output format, saturate.
  always_comb begin
    b_ext  = {{(S_W-BITSIZE-FRAC_BITS){b_q[j_q][BITSIZE-1]}}, b_q[j_q],
              {FRAC_BITS{1'b0}}};
    s_full = {acc[ACC_W-1], acc} + b_ext + HALF;
    r_full = $signed(s_full) >>> FRAC_BITS;
    r_hi   = r_full[S_W-1:BITSIZE-1];
    if ((&r_hi) || !(|r_hi)) begin
      sat_val = r_full[BITSIZE-1:0];
    end else if (r_full[S_W-1]) begin
      sat_val = {1'b1, {(BITSIZE-1){1'b0}}};
    end else begin
      sat_val = {1'b0, {(BITSIZE-1){1'b1}}};
    end
`ifdef DECODER_RELU_EN
    fin_val = sat_val[BITSIZE-1] ? '0 : sat_val;
`else
    fin_val = sat_val;
`endif
  end

  // Operand capture on accept so the caller may change inputs right after.
  always_ff @(posedge clk) begin
    if (accept) begin
      for (int i = 0; i < N_input; i++) begin
        z_q[i] <= z[i*BITSIZE +: BITSIZE];
        for (int j = 0; j < M_output; j++) begin
          w_q[i][j] <= w[(j*N_input+i)*BITSIZE +: BITSIZE];
        end
      end
      for (int j = 0; j < M_output; j++) begin
        b_q[j] <= b[j*BITSIZE +: BITSIZE];
      end
    end
  end

  // Control FSM: MAC one term per cycle, FIN finishes one output, DONE publishes.
  always_ff @(posedge clk) begin
    if (reset) begin
      state     <= IDLE;
      i_q       <= '0;
      j_q       <= '0;
      acc       <= '0;
      out       <= '0;
      out_valid <= 1'b0;
    end else begin
      if (out_valid && out_ready) begin
        out_valid <= 1'b0;
      end
      case (state)
        IDLE: begin
          if (accept) begin
            state <= MAC;
            i_q   <= '0;
            j_q   <= '0;
            acc   <= '0;
          end
        end
        MAC: begin
          acc <= acc + prod_ext;
          if (i_q == I_LAST) begin
            state <= FIN;
          end else begin
            i_q <= i_q + 1'b1;
          end
        end
        FIN: begin
          res_q[j_q] <= fin_val;
          acc        <= '0;
          i_q        <= '0;
          if (j_q == J_LAST) begin
            state <= DONE;
          end else begin
            j_q   <= j_q + 1'b1;
            state <= MAC;
          end
        end
        DONE: begin
          for (int j = 0; j < M_output; j++) begin
            out[j*BITSIZE +: BITSIZE] <= res_q[j];
          end
          out_valid <= 1'b1;
          state     <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_decoder_fixed_point_mac_seq.sv
// Bench for decoder_fixed_point_mac_seq: directed jobs, an arithmetic
// reference model, a result scoreboard and handshake/latency checks.
module tb_decoder_fixed_point_mac_seq;

  localparam int N   = 2;
  localparam int M   = 9;
  localparam int B   = 16;
  localparam int F   = 11;
  localparam int LAT = M*(N+1) + 1;

  logic             clk;
  logic             reset;
  logic             in_valid;
  logic             in_ready;
  logic [N*B-1:0]   z;
  logic [N*M*B-1:0] w;
  logic [M*B-1:0]   b;
  logic [M*B-1:0]   out;
  logic             out_valid;
  logic             out_ready;
  logic             busy;

  int checks = 0;
  int errors = 0;

  logic signed [B-1:0] zv [N];
  logic signed [B-1:0] wv [N][M];
  logic signed [B-1:0] bv [M];

  logic [M*B-1:0] exp_q[$];
  logic [M*B-1:0] cur_exp;
  logic           prev_v;

  decoder_fixed_point_mac_seq #(
    .N_input(N), .M_output(M), .BITSIZE(B), .FRAC_BITS(F)
  ) dut (
    .clk(clk), .reset(reset),
    .in_valid(in_valid), .in_ready(in_ready),
    .z(z), .w(w), .b(b),
    .out(out), .out_valid(out_valid), .out_ready(out_ready),
    .busy(busy)
  );

  // Clock/reset block
  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [M*B-1:0] act,
                     input logic [M*B-1:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // Reference model: plain integer arithmetic over the operand arrays.
  function automatic logic [M*B-1:0] model();
    logic [M*B-1:0] v;
    longint acc, s, r;
    v = '0;
    for (int j = 0; j < M; j++) begin
      acc = 0;
      for (int i = 0; i < N; i++) acc += longint'(zv[i]) * longint'(wv[i][j]);
      s = acc + (longint'(bv[j]) <<< F) + (longint'(1) <<< (F-1));
      r = s >>> F;
      if (r > 32767) r = 32767;
      if (r < -32768) r = -32768;
`ifdef DECODER_RELU_EN
      if (r < 0) r = 0;
`endif
      v[j*B +: B] = r[B-1:0];
    end
    return v;
  endfunction

  task automatic clear_vec();
    for (int i = 0; i < N; i++) begin
      zv[i] = '0;
      for (int j = 0; j < M; j++) wv[i][j] = '0;
    end
    for (int j = 0; j < M; j++) bv[j] = '0;
  endtask

  task automatic scramble_inputs();
    for (int k = 0; k < N; k++) z[k*B +: B] = B'($urandom_range(0, 65535));
    for (int k = 0; k < N*M; k++) w[k*B +: B] = B'($urandom_range(0, 65535));
    for (int k = 0; k < M; k++) b[k*B +: B] = B'($urandom_range(0, 65535));
  endtask

  // Driver: wait for in_ready (bounded), present one job, push its expectation.
  task automatic drive_job(output int waited);
    waited = 0;
    while (!in_ready && waited < 200) begin
      @(posedge clk); #1;
      waited++;
    end
    if (!in_ready) chk("in_ready_timeout", '0, 1);
    for (int i = 0; i < N; i++) begin
      z[i*B +: B] = zv[i];
      for (int j = 0; j < M; j++) w[(j*N+i)*B +: B] = wv[i][j];
    end
    for (int j = 0; j < M; j++) b[j*B +: B] = bv[j];
    in_valid = 1'b1;
    @(posedge clk); #1;
    in_valid = 1'b0;
    exp_q.push_back(model());
    scramble_inputs();
  endtask

  // Count edges from the accept edge until out_valid is seen.
  task automatic wait_result(input string name);
    int lat;
    lat = 0;
    do begin
      @(posedge clk); #1;
      lat++;
    end while (!out_valid && lat < 200);
    chk(name, lat, LAT);
  endtask

  task automatic take_result();
    out_ready = 1'b1;
    @(posedge clk); #1;
    out_ready = 1'b0;
    chk("take_out_valid", out_valid, 0);
    chk("take_in_ready", in_ready, 1);
  endtask

  // Scoreboard compare: every cycle out_valid is high, out must equal the head result.
  always @(negedge clk) begin
    if (out_valid) begin
      if (!prev_v) begin
        if (exp_q.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL unexpected_result: got %h expected none", out);
        end else begin
          cur_exp = exp_q.pop_front();
        end
      end
      chk("result", out, cur_exp);
    end
    prev_v = out_valid;
  end

  initial begin
    int n;
    logic [M*B-1:0] e;
    logic [M*B-1:0] held;
    prev_v    = 1'b0;
    cur_exp   = '0;
    reset     = 1'b1;
    in_valid  = 1'b0;
    out_ready = 1'b0;
    z = '0; w = '0; b = '0;
    clear_vec();
    repeat (3) @(posedge clk);
    #1 reset = 1'b0;
    chk("rst_out", out, 0);
    chk("rst_out_valid", out_valid, 0);
    chk("rst_busy", busy, 0);
    chk("rst_in_ready", in_ready, 1);

    // Basic
    clear_vec();
    zv[0] = 16'h0800; zv[1] = 16'h1000;
    wv[0][0] = 16'h0800; wv[1][0] = 16'h0800; bv[0] = 16'h0400;
    drive_job(n);
    chk("basic_busy", busy, 1);
    wait_result("basic_latency");
    e = '0; e[15:0] = 16'h1C00;
    chk("basic_literal", out, e);
    take_result();

    // Saturation
    clear_vec();
    zv[0] = 16'h7800; zv[1] = 16'h7800;
    wv[0][1] = 16'h7800; wv[1][1] = 16'h7800;
    wv[0][2] = 16'h8800; wv[1][2] = 16'h8800;
    drive_job(n);
    wait_result("sat_latency");
    e = '0; e[1*B +: B] = 16'h7FFF;
`ifndef DECODER_RELU_EN
    e[2*B +: B] = 16'h8000;
`endif
    chk("sat_literal", out, e);
    take_result();

    // Rounding
    clear_vec();
    zv[0] = 16'h0001; wv[0][3] = 16'h0400; wv[0][4] = 16'hFC00;
    drive_job(n);
    wait_result("round_latency");
    e = '0; e[3*B +: B] = 16'h0001;
    chk("round_literal", out, e);
    take_result();

    // Mixed signs
    clear_vec();
    zv[0] = 16'hF800; zv[1] = 16'h0C00;
    wv[0][0] = 16'h0800; wv[1][0] = 16'h0800; bv[0] = 16'h0200;
    wv[0][5] = 16'h1000; wv[1][5] = 16'hF000; bv[5] = 16'h0100;
    drive_job(n);
    wait_result("mixed_latency");
    e = '0; e[15:0] = 16'h0600;
`ifndef DECODER_RELU_EN
    e[5*B +: B] = 16'hD900;
`endif
    chk("mixed_literal", out, e);

    // Backpressure: hold the result, poke in_valid, nothing must be accepted
    held = out;
    for (int k = 0; k < 20; k++) begin
      chk("bp_in_ready", in_ready, 0);
      chk("bp_hold", out, held);
      chk("bp_valid", out_valid, 1);
      if (k == 5) begin
        scramble_inputs();
        in_valid = 1'b1;
      end
      @(posedge clk); #1;
      in_valid = 1'b0;
    end
    take_result();
    chk("bp_not_busy", busy, 0);
    clear_vec();
    zv[0] = 16'h0400; zv[1] = 16'hFC00;
    for (int j = 0; j < M; j++) begin
      wv[0][j] = 16'(j * 16'h0100);
      wv[1][j] = 16'h0200;
      bv[j]    = 16'(16'h0080 * j);
    end
    drive_job(n);
    wait_result("bp_next_latency");
    take_result();

    // Reset mid-job
    clear_vec();
    zv[0] = 16'h7000; zv[1] = 16'h7000;
    for (int j = 0; j < M; j++) begin wv[0][j] = 16'h7000; bv[j] = 16'h1234; end
    drive_job(n);
    repeat (9) @(posedge clk);
    #1;
    chk("mid_busy", busy, 1);
    reset = 1'b1;
    @(posedge clk); #1;
    reset = 1'b0;
    void'(exp_q.pop_back());
    chk("mid_rst_out", out, 0);
    chk("mid_rst_valid", out_valid, 0);
    chk("mid_rst_busy", busy, 0);
    chk("mid_rst_in_ready", in_ready, 1);
    clear_vec();
    zv[1] = 16'h0800; wv[1][8] = 16'h0C00; bv[7] = 16'hFF00;
    drive_job(n);
    wait_result("post_rst_latency");
    e = '0; e[8*B +: B] = 16'h0C00; e[7*B +: B] = 16'hFF00;
`ifdef DECODER_RELU_EN
    e[7*B +: B] = 16'h0000;
`endif
    chk("post_rst_literal", out, e);
    take_result();

    // Back-to-back with out_ready tied high
    out_ready = 1'b1;
    clear_vec();
    zv[0] = 16'h0C00; zv[1] = 16'h0400;
    for (int j = 0; j < M; j++) wv[0][j] = 16'(16'h0100 * (j + 1));
    drive_job(n);
    wait_result("b2b_first_latency");
    clear_vec();
    zv[0] = 16'hF000; zv[1] = 16'h0800;
    for (int j = 0; j < M; j++) begin wv[1][j] = 16'hF800; bv[j] = 16'h0080; end
    drive_job(n);
    chk("b2b_accept_gap", n, 1);
    wait_result("b2b_second_latency");
    @(posedge clk); #1;
    chk("b2b_cleared", out_valid, 0);
    out_ready = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    chk("scoreboard_empty", exp_q.size(), 0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/decoder_fixed_point_mac_seq.md
Name: decoder_fixed_point_mac_seq

Overview:
- Time-multiplexed, parametrised successor to the fully parallel fixed-point decoder layer.
- Computes out[j] = sat(round(sum_i w[i][j]*z[i]) + b[j]) for j = 0..M_output-1 on one shared multiply-accumulate (MAC) unit.
- Uses a valid/ready handshake on both input and output sides.
- Sits between the latent (z) stage and the next decoder layer. It trades latency for area when N_input and M_output grow.

Parameters:
- N_input, 2, number of latent inputs z[i].
- M_output, 9, number of outputs out[j].
- BITSIZE, 16, word width of z, w, b and out; two's complement.
- FRAC_BITS, 11, fractional bits (default Q4.11; 1.0 = 0x0800).

Ports:
- clk  in  1  rising-edge clock.
- reset  in  1  synchronous, active-high reset.
- in_valid  in  1  z, w and b are valid.
- in_ready  out  1  block accepts a new job.
- z  in  N_input*BITSIZE  z[i] at bits [i*BITSIZE +: BITSIZE].
- w  in  N_input*M_output*BITSIZE  w[i][j] at bits [(j*N_input+i)*BITSIZE +: BITSIZE].
- b  in  M_output*BITSIZE  b[j] at bits [j*BITSIZE +: BITSIZE].
- out  out  M_output*BITSIZE  out[j] at bits [j*BITSIZE +: BITSIZE].
- out_valid  out  1  out holds a completed result.
- out_ready  in  1  downstream consumes the result.
- busy  out  1  a job is in progress (state MAC or FIN).

Behaviour:
- One clock domain (clk). Reset is synchronous and active-high; all registers update on the rising edge of clk.
- Reset values:
  - out = 0, out_valid = 0, busy = 0, state = IDLE.
  - Internal counters i and j and the accumulator = 0.
  - in_ready = 1 from the first cycle after reset deasserts.
  - in_valid is ignored while reset is high.
- in_ready = (state == IDLE) && !out_valid.
- Accept: in_valid && in_ready at edge T.
  - z, w and b are copied into internal registers.
  - The caller may change the inputs afterwards.
- States:
  - IDLE: on accept, go to MAC; set i = 0, j = 0, acc = 0.
  - MAC: one cycle per i; acc += z[i]*w[i][j] (full 2*BITSIZE product). When i == N_input-1, go to FIN.
  - FIN: compute result[j] (see arithmetic rules), clear acc, i = 0. If j == M_output-1, go to DONE; else j++ and return to MAC.
  - DONE: copy result[0..M_output-1] into out, set out_valid = 1, go to IDLE.
- Latency:
  - out_valid rises at edge T + M_output*(N_input+1) + 1.
  - For the defaults this is 28 cycles after the accept edge.
- Arithmetic:
  - Accumulator width = 2*BITSIZE + clog2(N_input) + 1; it cannot overflow.
  - FIN: s = acc + (b[j] sign-extended, shifted left by FRAC_BITS) + (1 << (FRAC_BITS-1)).
  - r = s arithmetic-shifted right by FRAC_BITS (round half up).
  - Saturate r to [-(2^(BITSIZE-1)), 2^(BITSIZE-1)-1], i.e. 0x8000..0x7FFF for the defaults.
- Output handshake:
  - out and out_valid hold stable while out_valid && !out_ready.
  - out_valid && out_ready at an edge clears out_valid. out keeps its value.
  - in_ready rises in the next cycle.
  - out changes only on the edge where out_valid rises.
- Boundaries:
  - N_input = 1 gives one MAC cycle per output.
  - in_valid asserted while busy or while out_valid is pending is not accepted; inputs are not sampled.
  - Reset mid-job aborts the job; all outputs return to reset values on that edge.
  - Reset while out_valid is high clears out_valid and zeroes out.

Optional Feature:
- Macro: DECODER_RELU_EN.
- Defined: after saturation, negative results are forced to 0 (ReLU); positive and zero results are unchanged. Latency is unchanged.
- Undefined: the saturated signed result is output directly.

Test Plan:
- Basic:
  - Stimulus: z0 = 0x0800 (1.0), z1 = 0x1000 (2.0), w[0][0] = w[1][0] = 0x0800, b0 = 0x0400; all other w and b = 0.
  - Response: out[0] = 0x1C00 (3.5), out[1..8] = 0. out_valid rises exactly 28 cycles after the accept edge.
- Saturation:
  - Stimulus: z0 = z1 = 0x7800 (15.0) and w[0][1] = w[1][1] = 0x7800; separately, w[0][2] = w[1][2] = 0x8800 (-15.0).
  - Response: out[1] = 0x7FFF and out[2] = 0x8000. With DECODER_RELU_EN defined, out[2] = 0x0000.
- Rounding:
  - Stimulus: z0 = 0x0001, w[0][3] = 0x0400 (+0.5 LSB), w[0][4] = 0xFC00 (-0.5 LSB); z1 = 0; b = 0.
  - Response: out[3] = 0x0001 and out[4] = 0x0000.
- Backpressure:
  - Stimulus: hold out_ready = 0 for 20 cycles after out_valid rises, and pulse in_valid with new data during that window.
  - Response: out is stable, in_ready = 0 and the new data is not accepted. After out_ready = 1 for one cycle, out_valid = 0 and in_ready = 1 on the next cycle. The new job then produces its own result.
- Reset mid-job:
  - Stimulus: assert reset for 1 cycle 10 cycles after an accept.
  - Response: out = 0, out_valid = 0, busy = 0 and in_ready = 1 the cycle after. A following job produces the correct result with no residue from the aborted job.
- Back-to-back:
  - Stimulus: out_ready tied to 1; two jobs issued as soon as in_ready allows.
  - Response: both results are correct, and the second accept happens 1 cycle after the first result handshake.
